// File: rtl/cnn_score_argmax.sv
// Collects five per-class CNN score streams and serially reduces them to one (class, score) result.
// Optional ARGMAX_THRESHOLD_EN: results whose best score is below THRESHOLD report class 5 (reject).
module cnn_score_argmax #(
    parameter int DATA_WIDTH = 12,
    parameter int THRESHOLD  = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] score_0_TDATA,
    input  logic                  score_0_TVALID,
    output logic                  score_0_TREADY,
    input  logic [DATA_WIDTH-1:0] score_1_TDATA,
    input  logic                  score_1_TVALID,
    output logic                  score_1_TREADY,
    input  logic [DATA_WIDTH-1:0] score_2_TDATA,
    input  logic                  score_2_TVALID,
    output logic                  score_2_TREADY,
    input  logic [DATA_WIDTH-1:0] score_3_TDATA,
    input  logic                  score_3_TVALID,
    output logic                  score_3_TREADY,
    input  logic [DATA_WIDTH-1:0] score_4_TDATA,
    input  logic                  score_4_TVALID,
    output logic                  score_4_TREADY,
    output logic [2:0]            class_out,
    output logic [DATA_WIDTH-1:0] score_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  result_count
);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_SCAN,
        S_HOLD
    } state_t;

    state_t                r_state;
    logic [4:0]            r_captured;
    logic [DATA_WIDTH-1:0] r_score [5];
    logic [DATA_WIDTH-1:0] r_best;
    logic [2:0]            r_idx;
    logic [2:0]            r_scan_i;
    logic                  r_out_valid;
    logic [2:0]            r_class;
    logic [DATA_WIDTH-1:0] r_score_out;
    logic [CNT_WIDTH-1:0]  r_count;

    logic [DATA_WIDTH-1:0] w_tdata [5];
    logic [4:0]            w_valid;
    logic [4:0]            w_ready;
    logic [4:0]            w_xfer;
    logic [4:0]            w_captured_next;
    logic [DATA_WIDTH-1:0] w_cur_best;
    logic [2:0]            w_cur_idx;
    logic [DATA_WIDTH-1:0] w_cand;
    logic [DATA_WIDTH-1:0] w_next_best;
    logic [2:0]            w_next_idx;
    logic                  w_reject;

    assign w_tdata[0] = score_0_TDATA;
    assign w_tdata[1] = score_1_TDATA;
    assign w_tdata[2] = score_2_TDATA;
    assign w_tdata[3] = score_3_TDATA;
    assign w_tdata[4] = score_4_TDATA;
    assign w_valid    = {score_4_TVALID, score_3_TVALID, score_2_TVALID, score_1_TVALID, score_0_TVALID};

    // Each class accepts exactly one score per frame; nothing is accepted outside COLLECT.
    assign w_ready         = (r_state == S_COLLECT && !reset) ? ~r_captured : 5'b0;
    assign w_xfer          = w_valid & w_ready;
    assign w_captured_next = r_captured | w_xfer;

    assign score_0_TREADY = w_ready[0];
    assign score_1_TREADY = w_ready[1];
    assign score_2_TREADY = w_ready[2];
    assign score_3_TREADY = w_ready[3];
    assign score_4_TREADY = w_ready[4];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_cur_best = r_best;
        w_cur_idx  = r_idx;
        if (r_scan_i == 3'd1) begin
            w_cur_best = r_score[0];
            w_cur_idx  = 3'd0;
        end
        w_cand      = r_score[r_scan_i];
        w_next_best = w_cur_best;
        w_next_idx  = w_cur_idx;
        // Strict compare: on a tie the earlier (lower) class index keeps the win.
        if ($signed(w_cand) > $signed(w_cur_best)) begin
            w_next_best = w_cand;
            w_next_idx  = r_scan_i;
        end
    end

`ifdef ARGMAX_THRESHOLD_EN
    localparam logic signed [DATA_WIDTH-1:0] THRESHOLD_Q = DATA_WIDTH'(THRESHOLD);
    assign w_reject = $signed(w_next_best) < THRESHOLD_Q;
`else
    logic w_unused_threshold;
    assign w_unused_threshold = (THRESHOLD != 0);
    assign w_reject           = 1'b0;
`endif

    // NOTE: score holding registers carry no reset; r_captured alone says whether they are meaningful.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (w_xfer[k]) begin
                r_score[k] <= w_tdata[k];
            end
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_COLLECT;
            r_captured  <= '0;
            r_best      <= '0;
            r_idx       <= '0;
            r_scan_i    <= '0;
            r_out_valid <= 1'b0;
            r_class     <= '0;
            r_score_out <= '0;
            r_count     <= '0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    r_captured <= w_captured_next;
                    if (w_captured_next == 5'h1f) begin
                        r_state  <= S_SCAN;
                        r_scan_i <= 3'd1;
                    end
                end
                S_SCAN: begin
                    r_best   <= w_next_best;
                    r_idx    <= w_next_idx;
                    r_scan_i <= r_scan_i + 3'd1;
                    if (r_scan_i == 3'd4) begin
                        r_state     <= S_HOLD;
                        r_out_valid <= 1'b1;
                        r_class     <= w_reject ? 3'd5 : w_next_idx;
                        r_score_out <= w_next_best;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state     <= S_COLLECT;
                        r_captured  <= '0;
                        r_out_valid <= 1'b0;
                        r_count     <= r_count + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

    assign class_out    = r_class;
    assign score_out    = r_score_out;
    assign out_valid    = r_out_valid;
    assign result_count = r_count;

endmodule

// File: tb/tb_cnn_score_argmax.sv
// Scoreboard bench for cnn_score_argmax: expected results queued at frame start, popped on handshake.
// Honours ARGMAX_THRESHOLD_EN in its reference model; result_count is narrowed so wrap is reachable.
module tb_cnn_score_argmax;

    localparam int DW = 12;
    localparam int CW = 4;
    localparam int TH = 100;

    typedef logic signed [DW-1:0] score_t;
    typedef struct packed {
        logic [2:0] cls;
        score_t     score;
    } res_t;

    logic          clk = 1'b0;
    logic          reset;
    score_t        tdata [5];
    logic [4:0]    tvalid;
    logic [4:0]    tready;
    logic [2:0]    class_out;
    logic [DW-1:0] score_out;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] result_count;

    int            n_vec = 0;
    int            n_err = 0;
    res_t          exp_q [$];
    logic [CW-1:0] exp_count = '0;
    res_t          mon_e;
    score_t        frame [5];

    always #5 clk = ~clk;

    cnn_score_argmax #(
        .DATA_WIDTH(DW),
        .THRESHOLD (TH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .score_0_TDATA (tdata[0]),
        .score_0_TVALID(tvalid[0]),
        .score_0_TREADY(tready[0]),
        .score_1_TDATA (tdata[1]),
        .score_1_TVALID(tvalid[1]),
        .score_1_TREADY(tready[1]),
        .score_2_TDATA (tdata[2]),
        .score_2_TVALID(tvalid[2]),
        .score_2_TREADY(tready[2]),
        .score_3_TDATA (tdata[3]),
        .score_3_TVALID(tvalid[3]),
        .score_3_TREADY(tready[3]),
        .score_4_TDATA (tdata[4]),
        .score_4_TVALID(tvalid[4]),
        .score_4_TREADY(tready[4]),
        .class_out     (class_out),
        .score_out     (score_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result_count  (result_count)
    );

    // Reference argmax: first maximum wins, optional reject below threshold.
    function automatic res_t model_frame();
        res_t r;
        r.score = frame[0];
        r.cls   = 3'd0;
        for (int i = 1; i < 5; i++) begin
            if (frame[i] > r.score) begin
                r.score = frame[i];
                r.cls   = 3'(i);
            end
        end
`ifdef ARGMAX_THRESHOLD_EN
        if (r.score < score_t'(TH)) r.cls = 3'd5;
`endif
        return r;
    endfunction

    // Output monitor: every accepted result is popped and compared, along with the running count.
    always @(negedge clk) begin
        if (reset) begin
            exp_count = '0;
            exp_q.delete();
        end else if (out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: got class=%0d score=%0d, none expected", class_out, $signed(score_out));
            end else begin
                mon_e = exp_q.pop_front();
                if ({class_out, score_out} !== mon_e) begin
                    n_err++;
                    $display("FAIL result: got class=%0d score=%0d, want class=%0d score=%0d",
                             class_out, $signed(score_out), mon_e.cls, mon_e.score);
                end
            end
            n_vec++;
            if (result_count !== exp_count) begin
                n_err++;
                $display("FAIL result_count: got %0d, want %0d", result_count, exp_count);
            end
            exp_count = exp_count + 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_frame(input int a, input int b, input int c, input int d, input int e);
        frame[0] = score_t'(a);
        frame[1] = score_t'(b);
        frame[2] = score_t'(c);
        frame[3] = score_t'(d);
        frame[4] = score_t'(e);
    endtask

    // Presents class k from cycle st[k]; with keep4, class 4 stays valid (with new data) after capture.
    task automatic drive_frame(input logic [4:0][3:0] st, input logic keep4, output int n_cyc);
        logic [4:0] done;
        done  = '0;
        n_cyc = 0;
        for (int c = 0; c < 40 && done != 5'h1f; c++) begin
            step();
            for (int k = 0; k < 5; k++) begin
                tvalid[k] = (c >= int'(st[k])) && (!done[k] || (k == 4 && keep4));
                tdata[k]  = done[k] ? score_t'(1000) : frame[k];
            end
            @(negedge clk);
            if (keep4 && done[4]) begin
                n_vec++;
                if (tready[4] !== 1'b0) begin
                    n_err++;
                    $display("FAIL tready4_after_capture: got %b, want 0", tready[4]);
                end
            end
            for (int k = 0; k < 5; k++) begin
                if (tvalid[k] && tready[k]) done[k] = 1'b1;
            end
            n_cyc = c + 1;
        end
        step();
        tvalid = '0;
        if (done != 5'h1f) begin
            n_err++;
            $display("FAIL capture_timeout: captured %b, want 11111", done);
        end
    endtask

    // Called at the start of cycle T+1; returns at the negedge of the first out_valid cycle.
    task automatic wait_result();
        int lat;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        n_vec++;
        if (lat != 5) begin
            n_err++;
            $display("FAIL latency: got %0d cycles (0 = timeout), want 5", lat);
        end
    endtask

    task automatic run_frame(input logic [4:0][3:0] st, input logic keep4, input int exp_ncyc);
        int nc;
        exp_q.push_back(model_frame());
        drive_frame(st, keep4, nc);
        n_vec++;
        if (nc != exp_ncyc) begin
            n_err++;
            $display("FAIL xfer_cycles: got %0d, want %0d", nc, exp_ncyc);
        end
        wait_result();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        tvalid    = '0;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) tdata[k] = '0;
        step();
        step();
        @(negedge clk);
        n_vec++;
        if (tready !== 5'b0) begin
            n_err++;
            $display("FAIL tready_in_reset: got %b, want 00000", tready);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({out_valid, class_out, score_out, result_count, tready} !== {1'b0, 3'd0, 12'd0, 4'd0, 5'h1f}) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b class=%0d score=%0d count=%0d tready=%b, want 0/0/0/0/11111",
                     out_valid, class_out, score_out, result_count, tready);
        end
    endtask

    task automatic test_all_at_once();
        out_ready = 1'b1;
        set_frame(10, -3, 200, 7, 199);
        run_frame('0, 1'b0, 1);
        n_vec++;
        if (class_out !== 3'd2 || score_out !== 12'd200) begin
            n_err++;
            $display("FAIL basic_result: got class=%0d score=%0d, want class=2 score=200", class_out, $signed(score_out));
        end
        step();
        @(negedge clk);
        n_vec++;
        if (result_count !== 4'd1) begin
            n_err++;
            $display("FAIL basic_count: got %0d, want 1", result_count);
        end
    endtask

    task automatic test_order();
        // Arrival order 4,0,3,1,2; class 4 stays valid with different data after capture.
        set_frame(-100, 30, 300, -7, 299);
        run_frame({4'd0, 4'd2, 4'd4, 4'd3, 4'd1}, 1'b1, 5);
    endtask

    task automatic test_ties();
        set_frame(50, 50, -2048, 50, 0);
        run_frame('0, 1'b0, 1);
        set_frame(-2048, -2048, -2048, -2048, -2048);
        run_frame('0, 1'b0, 1);
        set_frame(0, 0, 0, 0, 2047);
        run_frame('0, 1'b0, 1);
        set_frame(-5, -1, -9, -1, -3);
        run_frame('0, 1'b0, 1);
    endtask

    task automatic test_hold();
        res_t held;
        step();
        out_ready = 1'b0;
        set_frame(5, 9, -1, 9, 3);
        held = model_frame();
        run_frame('0, 1'b0, 1);
        set_frame(-1, -2, -3, -4, -5);
        for (int c = 0; c < 10; c++) begin
            step();
            tvalid = 5'h1f;
            for (int k = 0; k < 5; k++) tdata[k] = frame[k];
            @(negedge clk);
            n_vec++;
            if ({out_valid, class_out, score_out, tready} !== {1'b1, held, 5'b0}) begin
                n_err++;
                $display("FAIL hold_stable: got valid=%b class=%0d score=%0d tready=%b, want 1/%0d/%0d/00000",
                         out_valid, class_out, $signed(score_out), tready, held.cls, held.score);
            end
        end
        step();
        out_ready = 1'b1;
        exp_q.push_back(model_frame());
        @(negedge clk);
        n_vec++;
        if (tready !== 5'b0) begin
            n_err++;
            $display("FAIL handoff_tready: got %b, want 00000", tready);
        end
        step();
        @(negedge clk);
        n_vec++;
        if (tready !== 5'h1f) begin
            n_err++;
            $display("FAIL next_frame_tready: got %b, want 11111", tready);
        end
        step();
        tvalid = '0;
        wait_result();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < 5; k++) frame[k] = score_t'($urandom_range(0, 4095));
            if (f % 5 == 0) frame[f % 4] = frame[4];
            run_frame('0, 1'b0, 1);
        end
    endtask

    task automatic test_reset_midframe();
        out_ready = 1'b1;
        set_frame(7, 8, 9, 0, 0);
        step();
        tvalid = 5'b00111;
        for (int k = 0; k < 5; k++) tdata[k] = frame[k];
        @(negedge clk);
        step();
        tvalid = '0;
        reset  = 1'b1;
        @(negedge clk);
        n_vec++;
        if (tready !== 5'b0) begin
            n_err++;
            $display("FAIL midframe_reset_tready: got %b, want 00000", tready);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({out_valid, class_out, score_out, result_count, tready} !== {1'b0, 3'd0, 12'd0, 4'd0, 5'h1f}) begin
            n_err++;
            $display("FAIL midframe_reset_state: got valid=%b class=%0d score=%0d count=%0d tready=%b, want 0/0/0/0/11111",
                     out_valid, class_out, score_out, result_count, tready);
        end
        set_frame(1, 2, 3, 4, 5);
        run_frame('0, 1'b0, 1);
    endtask

`ifdef ARGMAX_THRESHOLD_EN
    task automatic test_threshold();
        out_ready = 1'b1;
        set_frame(20, 30, 99, 0, -5);
        run_frame('0, 1'b0, 1);
        n_vec++;
        if (class_out !== 3'd5 || score_out !== 12'd99) begin
            n_err++;
            $display("FAIL reject: got class=%0d score=%0d, want class=5 score=99", class_out, $signed(score_out));
        end
        set_frame(20, 30, 100, 0, -5);
        run_frame('0, 1'b0, 1);
        n_vec++;
        if (class_out !== 3'd2 || score_out !== 12'd100) begin
            n_err++;
            $display("FAIL at_threshold: got class=%0d score=%0d, want class=2 score=100", class_out, $signed(score_out));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_all_at_once();
        test_order();
        test_ties();
        test_hold();
        test_back_to_back();
        test_reset_midframe();
`ifdef ARGMAX_THRESHOLD_EN
        test_threshold();
`endif
        step();
        step();
        @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results never produced, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
